// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter: shares the single DRAM command port between an L2 read
// requester, an L2 write requester and an internal refresh timer, running one
// four-phase cmd_req/cmd_ack handshake per command (IDLE -> ISSUE -> RELEASE).
// Optional feature: define DRAM_ARB_ROW_HIT_EN to prefer the rd/wr requester
// whose bank+row matches the last issued rd/wr command when both request.
module dram_cmd_arbiter #(
  parameter  int unsigned NUM_OF_BANKS     = 8,
  parameter  int unsigned NUM_OF_ROWS      = 128,
  parameter  int unsigned NUM_OF_COLS      = 8,
  parameter  int unsigned REFRESH_INTERVAL = 512,
  localparam int unsigned BANK_W           = $clog2(NUM_OF_BANKS),
  localparam int unsigned ROW_W            = $clog2(NUM_OF_ROWS),
  localparam int unsigned COL_W            = $clog2(NUM_OF_COLS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              rd_req,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic              rd_gnt,
  input  logic              wr_req,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  output logic              wr_gnt,
  output logic              cmd_req,
  input  logic              cmd_ack,
  output logic [1:0]        cmd,
  output logic [BANK_W-1:0] bank_id,
  output logic [ROW_W-1:0]  row_id,
  output logic [COL_W-1:0]  col_id,
  output logic              ref_overrun
);

  localparam int unsigned     CNT_W    = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ISSUE   = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_REF  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ovr_q, ovr_d;
  logic              rr_q, rr_d;        // 0: read goes first, 1: write goes first
  logic              cmd_req_q, cmd_req_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              ref_wrap;
  logic              ref_clr;
  logic              take_rd;

`ifdef DRAM_ARB_ROW_HIT_EN
  logic              hit_vld_q, hit_vld_d;
  logic [BANK_W-1:0] hit_bank_q, hit_bank_d;
  logic [ROW_W-1:0]  hit_row_q, hit_row_d;
  logic              rd_hit, wr_hit;

  assign rd_hit = hit_vld_q && (rd_bank == hit_bank_q) && (rd_row == hit_row_q);
  assign wr_hit = hit_vld_q && (wr_bank == hit_bank_q) && (wr_row == hit_row_q);
`endif

  // Free-running refresh timer; the wrap cycle is the refresh tick
  always_comb begin
    ref_wrap = (cnt_q == CNT_LAST);
    cnt_d    = ref_wrap ? '0 : cnt_q + 1'b1;
  end

  // Read/write selection: round-robin, optionally overridden by a row hit
  always_comb begin
    take_rd = rd_req && (!wr_req || !rr_q);
`ifdef DRAM_ARB_ROW_HIT_EN
    if (rd_req && wr_req && (rd_hit != wr_hit)) take_rd = rd_hit;
`endif
  end

  // Handshake FSM next-state, command latch and refresh bookkeeping
  always_comb begin
    state_d   = state_q;
    cmd_req_d = cmd_req_q;
    cmd_d     = cmd_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    rr_d      = rr_q;
    rd_gnt_d  = 1'b0;
    wr_gnt_d  = 1'b0;
    ref_clr   = 1'b0;
`ifdef DRAM_ARB_ROW_HIT_EN
    hit_vld_d  = hit_vld_q;
    hit_bank_d = hit_bank_q;
    hit_row_d  = hit_row_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ref_pend_q) begin
          cmd_req_d = 1'b1;
          cmd_d     = CMD_REF;
          bank_d    = '0;
          row_d     = '0;
          col_d     = '0;
          state_d   = ST_ISSUE;
`ifdef DRAM_ARB_ROW_HIT_EN
          hit_vld_d = 1'b0;
`endif
        end else if (rd_req || wr_req) begin
          cmd_req_d = 1'b1;
          state_d   = ST_ISSUE;
          if (take_rd) begin
            cmd_d  = CMD_RD;
            bank_d = rd_bank;
            row_d  = rd_row;
            col_d  = rd_col;
          end else begin
            cmd_d  = CMD_WR;
            bank_d = wr_bank;
            row_d  = wr_row;
            col_d  = wr_col;
          end
`ifdef DRAM_ARB_ROW_HIT_EN
          hit_vld_d  = 1'b1;
          hit_bank_d = take_rd ? rd_bank : wr_bank;
          hit_row_d  = take_rd ? rd_row : wr_row;
`endif
        end
      end
      ST_ISSUE: begin
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          cmd_d     = CMD_IDLE;
          state_d   = ST_RELEASE;
          case (cmd_q)
            CMD_RD: begin
              rd_gnt_d = 1'b1;
              rr_d     = 1'b1;
            end
            CMD_WR: begin
              wr_gnt_d = 1'b1;
              rr_d     = 1'b0;
            end
            default: ref_clr = 1'b1;
          endcase
        end
      end
      ST_RELEASE: begin
        if (!cmd_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A tick coinciding with the refresh completion keeps refresh pending
    ref_pend_d = ref_wrap | (ref_pend_q & ~ref_clr);
    ovr_d      = ovr_q | (ref_wrap & ref_pend_q);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ref_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
      rr_q       <= 1'b0;
      cmd_req_q  <= 1'b0;
      cmd_q      <= CMD_IDLE;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_pend_q <= ref_pend_d;
      ovr_q      <= ovr_d;
      rr_q       <= rr_d;
      cmd_req_q  <= cmd_req_d;
      cmd_q      <= cmd_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
    end
  end

`ifdef DRAM_ARB_ROW_HIT_EN
  // Record of the last issued rd/wr bank+row
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_vld_q  <= 1'b0;
      hit_bank_q <= '0;
      hit_row_q  <= '0;
    end else begin
      hit_vld_q  <= hit_vld_d;
      hit_bank_q <= hit_bank_d;
      hit_row_q  <= hit_row_d;
    end
  end
`endif

  assign cmd_req     = cmd_req_q;
  assign cmd         = cmd_q;
  assign bank_id     = bank_q;
  assign row_id      = row_q;
  assign col_id      = col_q;
  assign rd_gnt      = rd_gnt_q;
  assign wr_gnt      = wr_gnt_q;
  assign ref_overrun = ovr_q;

endmodule
